// File: rtl/pmem_arbiter_burst_pkg.sv
// Shared types and geometry for the L1-to-burst-memory arbiter.
package pmem_arb_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BURST_W     = 64;
  localparam int unsigned BEATS       = LINE_W / BURST_W;
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/pmem_arbiter_burst_if.sv
// Cache-side and memory-side signals of the arbiter.
// slave: the arbiter's view; master: the caches/memory driving it.
interface pmem_arbiter_burst_if #(
  parameter int unsigned LINE_W  = pmem_arb_pkg::LINE_W,
  parameter int unsigned BURST_W = pmem_arb_pkg::BURST_W,
  parameter int unsigned ADDR_W  = 32
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BURST_W-1:0] mem_wdata;
  logic [BURST_W-1:0] mem_rdata;
  logic               mem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/pmem_arbiter_burst_line_beat_buffer.sv
// One cache line of storage addressable as whole line or as burst beats.
module line_beat_buffer #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [LINE_W-1:0]  load_data,
  input  logic               beat_we,
  input  logic [IDX_W-1:0]   beat_idx,
  input  logic [BURST_W-1:0] beat_wdata,
  output logic [BURST_W-1:0] beat_rdata,
  output logic [LINE_W-1:0]  line_q
);

  // Parallel load has priority over the per-beat write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_data;
    end else if (beat_we) begin
      line_q[32'(beat_idx) * BURST_W +: BURST_W] <= beat_wdata;
    end
  end

  // Beat select for the outgoing write burst
  always_comb begin
    beat_rdata = line_q[32'(beat_idx) * BURST_W +: BURST_W];
  end

endmodule

// File: rtl/pmem_arbiter_burst.sv
// Arbitrates icache/dcache line traffic onto one burst memory port,
// splitting lines into beats and reassembling them.
module pmem_arbiter_burst #(
  parameter int unsigned LINE_W  = pmem_arb_pkg::LINE_W,
  parameter int unsigned BURST_W = pmem_arb_pkg::BURST_W,
  parameter int unsigned ADDR_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  pmem_arbiter_burst_if.slave itf
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  import pmem_arb_pkg::*;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  state_t             state;
  grant_t             last_grant;
  logic [IDX_W-1:0]   beat;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               i_resp_q;
  logic               d_resp_q;
  logic [LINE_W-1:0]  i_rdata_q;
  logic [LINE_W-1:0]  d_rdata_q;

  logic               i_pend;
  logic               d_pend;
  logic               grant_i;
  logic               grant_d;
  logic               in_burst;
  logic               buf_load;
  logic               buf_we;
  logic [BURST_W-1:0] buf_beat;
  logic [LINE_W-1:0]  line_q;
  logic [LINE_W-1:0]  assembled;

  // Request decode and round-robin tie-break against the previous grant
  always_comb begin
    i_pend   = itf.i_read;
    d_pend   = itf.d_read | itf.d_write;
    grant_d  = (state == IDLE) && d_pend && (!i_pend || last_grant == GNT_I);
    grant_i  = (state == IDLE) && i_pend && !grant_d;
    in_burst = (state == I_RD) || (state == D_RD) || (state == D_WR);
    buf_load = grant_d && itf.d_write;
    buf_we   = itf.mem_resp && ((state == I_RD) || (state == D_RD));
  end

  // The final beat lands in the buffer on the same edge the response is
  // registered, so the response line merges it in directly.
  always_comb begin
    assembled = line_q;
    assembled[LINE_W-BURST_W +: BURST_W] = itf.mem_rdata;
  end

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_en    (buf_load),
    .load_data  (itf.d_wdata),
    .beat_we    (buf_we),
    .beat_idx   (beat),
    .beat_wdata (itf.mem_rdata),
    .beat_rdata (buf_beat),
    .line_q     (line_q)
  );

  // Arbitration FSM with registered memory and cache-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= GNT_I;
      beat        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            last_grant <= GNT_D;
            mem_addr_q <= {itf.d_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            if (itf.d_write) begin
              state       <= D_WR;
              mem_write_q <= 1'b1;
            end else begin
              state      <= D_RD;
              mem_read_q <= 1'b1;
            end
          end else if (grant_i) begin
            last_grant <= GNT_I;
            mem_addr_q <= {itf.i_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            state      <= I_RD;
            mem_read_q <= 1'b1;
          end
        end
        I_RD, D_RD, D_WR: begin
          if (itf.mem_resp) begin
            if (beat == LAST_BEAT) begin
              state       <= DONE;
              beat        <= '0;
              mem_read_q  <= 1'b0;
              mem_write_q <= 1'b0;
              if (state == I_RD) begin
                i_resp_q  <= 1'b1;
                i_rdata_q <= assembled;
              end else begin
                d_resp_q  <= 1'b1;
                d_rdata_q <= (state == D_WR) ? '0 : assembled;
              end
            end else begin
              beat <= beat + IDX_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    itf.mem_read  = mem_read_q;
    itf.mem_write = mem_write_q;
    itf.mem_addr  = mem_addr_q;
    itf.mem_wdata = mem_write_q ? buf_beat : '0;
    itf.i_resp    = i_resp_q;
    itf.i_rdata   = i_rdata_q;
    itf.d_resp    = d_resp_q;
    itf.d_rdata   = d_rdata_q;
  end

  // A dcache read+write collision is served as a writeback but is a caller bug
  assert property (@(posedge clk) disable iff (!rst)
    (state == IDLE) |-> !(itf.d_read && itf.d_write));

  // Memory beats are only meaningful while a burst is in flight
  assert property (@(posedge clk) disable iff (!rst)
    itf.mem_resp |-> in_burst);

endmodule

// File: tb/tb_pmem_arbiter_burst.sv
module tb_pmem_arbiter_burst;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   last_d = 1'b0;

  pmem_arbiter_burst_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) itf ();

  pmem_arbiter_burst #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .itf (itf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One complete transaction seen from the memory side: wait for the grant,
  // feed/collect four beats, then check the single-cycle response.
  task automatic run_txn(input string tag, input bit is_d, input bit is_wr,
                         input logic [31:0] addr, input logic [255:0] line,
                         input int unsigned gap, input bit drop_i, input bit drop_d);
    logic [255:0] wline;
    logic [31:0]  aaddr;
    wline = '0;
    aaddr = {addr[31:5], 5'b0};
    for (int c = 0; c < 20 && !(itf.mem_read || itf.mem_write); c++) @(negedge clk);
    chk({tag, "_grant"}, 256'(itf.mem_read | itf.mem_write), 256'(1));
    if (!(itf.mem_read || itf.mem_write)) return;
    chk({tag, "_kind"}, {itf.mem_read, itf.mem_write, itf.mem_addr}, {~is_wr, is_wr, aaddr});
    last_d = is_d;
    if (is_d) begin
      itf.d_addr  = $urandom;
      itf.d_wdata = rand_line();
    end else begin
      itf.i_addr = $urandom;
    end
    for (int b = 0; b < 4; b++) begin
      for (int unsigned g = 0; g < gap; g++) begin
        chk({tag, "_gap"}, {itf.mem_read, itf.mem_write, itf.i_resp, itf.d_resp, itf.mem_addr},
            {~is_wr, is_wr, 2'b00, aaddr});
        @(negedge clk);
      end
      chk({tag, "_beat"}, {itf.mem_read, itf.mem_write, itf.i_resp, itf.d_resp, itf.mem_addr},
          {~is_wr, is_wr, 2'b00, aaddr});
      wline[b*64 +: 64] = itf.mem_wdata;
      itf.mem_rdata = line[b*64 +: 64];
      itf.mem_resp  = 1'b1;
      @(negedge clk);
      itf.mem_resp  = 1'b0;
      itf.mem_rdata = '0;
    end
    chk({tag, "_resp"}, {itf.i_resp, itf.d_resp, itf.mem_read, itf.mem_write}, {~is_d, is_d, 2'b00});
    if (is_d) chk({tag, "_d_rdata"}, itf.d_rdata, is_wr ? 256'b0 : line);
    else      chk({tag, "_i_rdata"}, itf.i_rdata, line);
    if (is_wr) chk({tag, "_wbeats"}, wline, line);
    if (drop_i) itf.i_read = 1'b0;
    if (drop_d) begin
      itf.d_read  = 1'b0;
      itf.d_write = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_resp_1cyc"}, {itf.i_resp, itf.d_resp}, 2'b00);
  endtask

  initial begin
    logic [255:0] line1, line;
    logic [31:0]  a;
    bit           want_d;

    itf.i_read = 0; itf.i_addr = '0;
    itf.d_read = 0; itf.d_write = 0; itf.d_addr = '0; itf.d_wdata = '0;
    itf.mem_rdata = '0; itf.mem_resp = 0;

    // Reset held with memory beats toggling: nothing may leak out
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      itf.mem_resp  = ~itf.mem_resp;
      itf.mem_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("rst_mem", {itf.mem_read, itf.mem_write, itf.mem_addr, itf.mem_wdata}, '0);
    chk("rst_resp", {itf.i_resp, itf.d_resp}, '0);
    chk("rst_i_rdata", itf.i_rdata, '0);
    chk("rst_d_rdata", itf.d_rdata, '0);

    // Release and issue an icache read; mem_read must follow one edge later
    itf.mem_resp = 0; itf.mem_rdata = '0;
    rst = 1'b1;
    itf.i_read = 1'b1; itf.i_addr = 32'h60;
    @(negedge clk);
    chk("lat_grant", {itf.mem_read, itf.mem_addr}, {1'b1, 32'h60});
    line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn("i_rd", 1'b0, 1'b0, 32'h60, line1, 0, 1'b1, 1'b0);

    // dcache writeback with two idle cycles between beats
    line = rand_line();
    itf.d_addr = 32'h1234_5678; itf.d_wdata = line; itf.d_write = 1'b1;
    run_txn("d_wr", 1'b1, 1'b1, 32'h1234_5678, line, 2, 1'b0, 1'b1);
    chk("i_rdata_hold", itf.i_rdata, line1);

    // Contention right after reset: D first, then the held I immediately
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_d = 1'b0;
    itf.i_addr = $urandom; itf.d_addr = $urandom;
    a = itf.i_addr;
    itf.i_read = 1'b1; itf.d_read = 1'b1;
    run_txn("cont_d", 1'b1, 1'b0, itf.d_addr, rand_line(), 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("cont_i_next", {itf.mem_read, itf.mem_addr}, {1'b1, a[31:5], 5'b0});
    run_txn("cont_i", 1'b0, 1'b0, a, rand_line(), 0, 1'b1, 1'b0);

    // Fairness: both requests held continuously -> strict alternation
    itf.i_addr = $urandom; itf.d_addr = $urandom;
    itf.i_read = 1'b1; itf.d_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      want_d = !last_d;
      a = want_d ? itf.d_addr : itf.i_addr;
      run_txn(want_d ? "fair_d" : "fair_i", want_d, 1'b0, a, rand_line(),
              $urandom_range(0, 2), t == 3, t == 3);
      if (want_d) itf.d_addr = $urandom;
      else        itf.i_addr = $urandom;
    end

    // Abort mid-burst, then a clean transaction with fresh data
    itf.i_addr = $urandom; itf.i_read = 1'b1;
    for (int c = 0; c < 20 && !itf.mem_read; c++) @(negedge clk);
    chk("abort_grant", 256'(itf.mem_read), 256'(1));
    for (int b = 0; b < 2; b++) begin
      itf.mem_rdata = {$urandom, $urandom}; itf.mem_resp = 1'b1;
      @(negedge clk);
      itf.mem_resp = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("abort_async", {itf.mem_read, itf.mem_write, itf.mem_addr, itf.i_resp, itf.d_resp}, '0);
    chk("abort_i_rdata", itf.i_rdata, '0);
    itf.i_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_d = 1'b0;
    itf.i_addr = $urandom; itf.i_read = 1'b1;
    run_txn("post_abort", 1'b0, 1'b0, itf.i_addr, rand_line(), 1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
